// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard detection unit.
// Optional build macro used by the unit: HAZ_PERF_CNT_EN (stall/flush perf counters).
package hazard_pkg;

  // Controller states: normal run, the single load-use bubble, waiting on data memory
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } hz_state_e;

  // Register specifier of the hard-wired zero register; never a real dependency
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect_unit_if.sv
// Pipeline <-> hazard unit bundle: hazard sources in, stall/flush enables out.
interface hazard_detect_unit_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] iRs_RegD;
  logic [REG_W-1:0] iRt_RegD;
  logic             iUseRt_D;
  logic             iMemRead_RegE;
  logic [REG_W-1:0] iwsel_RegE;
  logic             iBranchTaken_E;
  logic             iICacheStall;
  logic             iDCacheStall;
  logic             oStall_PC;
  logic             oStall_IFID;
  logic             oFlush_IFID;
  logic             oStall_IDEX;
  logic             oFlush_IDEX;
  logic             oStall_EXMEM;
  logic             oStall_MEMWB;

  // Pipeline side: reports hazard sources, consumes the enables
  modport master (
    output iRs_RegD, iRt_RegD, iUseRt_D, iMemRead_RegE, iwsel_RegE,
           iBranchTaken_E, iICacheStall, iDCacheStall,
    input  oStall_PC, oStall_IFID, oFlush_IFID, oStall_IDEX, oFlush_IDEX,
           oStall_EXMEM, oStall_MEMWB
  );

  // Hazard unit side
  modport slave (
    input  iRs_RegD, iRt_RegD, iUseRt_D, iMemRead_RegE, iwsel_RegE,
           iBranchTaken_E, iICacheStall, iDCacheStall,
    output oStall_PC, oStall_IFID, oFlush_IFID, oStall_IDEX, oFlush_IDEX,
           oStall_EXMEM, oStall_MEMWB
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Two saturating event counters: cycles with a PC stall and cycles with an IF/ID flush.
// Only instantiated when HAZ_PERF_CNT_EN is defined.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Next counter values
  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, stall_i);
    flush_cnt_d = sat_inc(flush_cnt_q, flush_i);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, I/D memory busy.
// Enables are combinational from state + inputs (zero latency) and forced low in reset.
// Optional build macro: HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_detect_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_detect_unit_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0]   oStallCnt
  , output logic [CNT_W-1:0]   oFlushCnt
`endif
);

  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(REG_ZERO);

  hz_state_e state_q, state_d;
  logic      flush_pend_q, flush_pend_d;
  logic      lu_hit_s;
  logic      stall_pc_s, stall_ifid_s, flush_ifid_s, stall_idex_s, flush_idex_s;
  logic      stall_exmem_s, stall_memwb_s;

  // Load in EX writing a register the ID instruction reads (r0 never counts)
  always_comb begin
    lu_hit_s = hz.iMemRead_RegE & (hz.iwsel_RegE != ZERO_REG) &
               ((hz.iwsel_RegE == hz.iRs_RegD) |
                (hz.iUseRt_D & (hz.iwsel_RegE == hz.iRt_RegD)));
  end

  // Prioritised hazard resolution: D-stall > branch (live/pending) > load-use > I-stall
  always_comb begin
    stall_pc_s    = 1'b0;
    stall_ifid_s  = 1'b0;
    flush_ifid_s  = 1'b0;
    stall_idex_s  = 1'b0;
    flush_idex_s  = 1'b0;
    stall_exmem_s = 1'b0;
    stall_memwb_s = 1'b0;
    state_d       = RUN;
    flush_pend_d  = flush_pend_q;
    if (hz.iDCacheStall) begin
      // Whole pipe frozen; a branch resolving now must be replayed once memory returns
      stall_pc_s    = 1'b1;
      stall_ifid_s  = 1'b1;
      stall_idex_s  = 1'b1;
      stall_exmem_s = 1'b1;
      stall_memwb_s = 1'b1;
      state_d       = MEM_WAIT;
      flush_pend_d  = flush_pend_q | hz.iBranchTaken_E;
    end else if (hz.iBranchTaken_E || flush_pend_q) begin
      // Wrong-path instructions are discarded; this also squashes any load-use
      flush_ifid_s  = 1'b1;
      flush_idex_s  = 1'b1;
      flush_pend_d  = 1'b0;
    end else if (lu_hit_s && (state_q != LU_BUBBLE)) begin
      // Exactly one bubble per load; the hazard is masked in the bubble cycle
      stall_pc_s    = 1'b1;
      stall_ifid_s  = 1'b1;
      flush_idex_s  = 1'b1;
      state_d       = LU_BUBBLE;
    end else if (hz.iICacheStall) begin
      // Front end waits, a bubble drains into EX while later stages keep moving
      stall_pc_s    = 1'b1;
      stall_ifid_s  = 1'b1;
      flush_idex_s  = 1'b1;
    end else begin
      state_d       = RUN;
    end
  end

  // State and pending-flush registers; reset drops any pending flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Drive enables, held low while reset is asserted
  always_comb begin
    hz.oStall_PC    = rst_n & stall_pc_s;
    hz.oStall_IFID  = rst_n & stall_ifid_s;
    hz.oFlush_IFID  = rst_n & flush_ifid_s;
    hz.oStall_IDEX  = rst_n & stall_idex_s;
    hz.oFlush_IDEX  = rst_n & flush_idex_s;
    hz.oStall_EXMEM = rst_n & stall_exmem_s;
    hz.oStall_MEMWB = rst_n & stall_memwb_s;
  end

`ifdef HAZ_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (hz.oStall_PC),
    .flush_i     (hz.oFlush_IFID),
    .stall_cnt_o (oStallCnt),
    .flush_cnt_o (oFlushCnt)
  );
`endif

endmodule
